// File: rtl/int_ctrl_if.sv
// int_ctrl bus: interrupt lines, mask load, CPU handshake, status.
// master = CPU/stimulus side, slave = the controller.
interface int_ctrl_if #(
  parameter int NUM_IRQ = 8
);
  localparam int VW = $clog2(NUM_IRQ);

  logic [NUM_IRQ-1:0] irq;
  logic [NUM_IRQ-1:0] mask_in;
  logic               ld_mask;
  logic               int_ack;
  logic               int_eoi;
  logic               hwint;
  logic [VW-1:0]      int_vec;
  logic               in_service;
  logic [NUM_IRQ-1:0] pending;

  modport master (
    output irq, mask_in, ld_mask,
    output int_ack, int_eoi,
    input  hwint, int_vec,
    input  in_service, pending
  );

  modport slave (
    input  irq, mask_in, ld_mask,
    input  int_ack, int_eoi,
    output hwint, int_vec,
    output in_service, pending
  );
endinterface

// File: rtl/int_ctrl.sv
// Fixed-priority interrupt controller, IDLE/REQ/SERVICE handshake.
// Define INT_CTRL_EDGE_DETECT_EN for edge-triggered sources.
module int_ctrl #(
  parameter int NUM_IRQ = 8
) (
  input logic     clk,
  input logic     rst,
  int_ctrl_if.slave bus
);
  localparam int VW = $clog2(NUM_IRQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] elig;
  logic [VW-1:0]      vec;
  logic [VW-1:0]      sel;
  logic               hw;
  logic               svc;
  logic               any;
  logic               withdraw;

  assign elig = pend & mask;
  assign any  = |elig;

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) sel = VW'(i);
    end
  end

  assign withdraw = bus.ld_mask & ~bus.mask_in[vec];

  always_ff @(posedge clk) begin
    if (rst) mask <= '0;
    else if (bus.ld_mask) mask <= bus.mask_in;
  end

`ifdef INT_CTRL_EDGE_DETECT_EN
  logic [NUM_IRQ-1:0] hist;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] clr;

  assign rise = bus.irq & ~hist;
  assign clr  = (state == REQ && bus.int_ack)
              ? (NUM_IRQ'(1) << vec) : '0;

  // Clear before set so a fresh edge in the ack cycle survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist <= '0;
      pend <= '0;
    end else begin
      hist <= bus.irq;
      pend <= (pend & ~clr) | rise;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else pend <= bus.irq;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hw    <= 1'b0;
      vec   <= '0;
      svc   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state <= REQ;
            vec   <= sel;
            hw    <= 1'b1;
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            state <= SERVICE;
            hw    <= 1'b0;
            svc   <= 1'b1;
          end else if (withdraw) begin
            state <= IDLE;
            hw    <= 1'b0;
          end
        end
        SERVICE: begin
          if (bus.int_eoi) begin
            state <= IDLE;
            svc   <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          hw    <= 1'b0;
          svc   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.hwint      = hw;
  assign bus.int_vec    = vec;
  assign bus.in_service = svc;
  assign bus.pending    = pend;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl, level build by default;
// edge build selected by INT_CTRL_EDGE_DETECT_EN.
module tb_int_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  int_ctrl_if #(.NUM_IRQ(8)) bus ();

  int_ctrl #(.NUM_IRQ(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_mask(input logic [7:0] m);
    bus.ld_mask = 1'b1;
    bus.mask_in = m;
    step();
    bus.ld_mask = 1'b0;
  endtask

  initial begin
    bus.irq     = '0;
    bus.mask_in = '0;
    bus.ld_mask = 1'b0;
    bus.int_ack = 1'b0;
    bus.int_eoi = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_hwint", 32'(bus.hwint), 0);
    chk("rst_vec", 32'(bus.int_vec), 0);
    chk("rst_svc", 32'(bus.in_service), 0);
    chk("rst_pend", 32'(bus.pending), 0);

    // single source, full handshake
    load_mask(8'hFF);
    bus.irq = 8'h01;
    step();
    bus.irq = 8'h00;
    chk("t1_pend", 32'(bus.pending), 32'h01);
    chk("t1_hw_lat", 32'(bus.hwint), 0);
    step();
    chk("t1_hwint", 32'(bus.hwint), 1);
    chk("t1_vec", 32'(bus.int_vec), 0);
    bus.int_ack = 1'b1;
    step();
    bus.int_ack = 1'b0;
    chk("t1_ack_hw", 32'(bus.hwint), 0);
    chk("t1_ack_svc", 32'(bus.in_service), 1);
    chk("t1_ack_pend", 32'(bus.pending), 0);
    bus.int_eoi = 1'b1;
    step();
    bus.int_eoi = 1'b0;
    chk("t1_eoi_svc", 32'(bus.in_service), 0);
    step();
    chk("t1_idle_hw", 32'(bus.hwint), 0);

    // priority: bits 3 and 5 together
    bus.irq = 8'h28;
    step();
    step();
    chk("t2_hwint", 32'(bus.hwint), 1);
    chk("t2_vec3", 32'(bus.int_vec), 3);
    bus.int_ack = 1'b1;
    bus.irq = 8'h20;
    step();
    bus.int_ack = 1'b0;
    chk("t2_svc", 32'(bus.in_service), 1);
    chk("t2_svc_vec", 32'(bus.int_vec), 3);
    chk("t2_pend", 32'(bus.pending), 32'h20);
    bus.int_eoi = 1'b1;
    step();
    bus.int_eoi = 1'b0;
    chk("t2_eoi_svc", 32'(bus.in_service), 0);
    chk("t2_nonest", 32'(bus.hwint), 0);
    step();
    chk("t2_re_hw", 32'(bus.hwint), 1);
    chk("t2_vec5", 32'(bus.int_vec), 5);
    bus.int_ack = 1'b1;
    bus.irq = 8'h00;
    step();
    bus.int_ack = 1'b0;
    bus.int_eoi = 1'b1;
    step();
    bus.int_eoi = 1'b0;
    step();
    chk("t2_done_hw", 32'(bus.hwint), 0);

    // masked source stays pending until unmasked
    load_mask(8'h00);
    bus.irq = 8'h04;
    step();
    step();
    chk("t3_pend", 32'(bus.pending), 32'h04);
    chk("t3_masked", 32'(bus.hwint), 0);
    step();
    chk("t3_masked2", 32'(bus.hwint), 0);
    load_mask(8'h04);
    chk("t3_ld_hw", 32'(bus.hwint), 0);
    step();
    chk("t3_hwint", 32'(bus.hwint), 1);
    chk("t3_vec2", 32'(bus.int_vec), 2);
    bus.int_ack = 1'b1;
    bus.irq = 8'h00;
    step();
    bus.int_ack = 1'b0;
    bus.int_eoi = 1'b1;
    step();
    bus.int_eoi = 1'b0;
    step();

    // withdrawal by masking, then ack beats withdrawal
    load_mask(8'hFF);
    bus.irq = 8'h02;
    step();
    step();
    chk("t4_hwint", 32'(bus.hwint), 1);
    chk("t4_vec1", 32'(bus.int_vec), 1);
    load_mask(8'h00);
    chk("t4_wd_hw", 32'(bus.hwint), 0);
    chk("t4_wd_svc", 32'(bus.in_service), 0);
    load_mask(8'hFF);
    step();
    chk("t4_re_hw", 32'(bus.hwint), 1);
    chk("t4_re_vec", 32'(bus.int_vec), 1);
    bus.ld_mask = 1'b1;
    bus.mask_in = 8'h00;
    bus.int_ack = 1'b1;
    bus.irq = 8'h00;
    step();
    bus.ld_mask = 1'b0;
    bus.int_ack = 1'b0;
    chk("t4_ackwin_svc", 32'(bus.in_service), 1);
    chk("t4_ackwin_hw", 32'(bus.hwint), 0);
    bus.int_eoi = 1'b1;
    step();
    bus.int_eoi = 1'b0;
    step();
    chk("t4_done_hw", 32'(bus.hwint), 0);

    // re-request of the in-service source, then reset in SERVICE
    load_mask(8'hFF);
    bus.irq = 8'h10;
    step();
    step();
    chk("t5_vec4", 32'(bus.int_vec), 4);
    bus.int_ack = 1'b1;
    step();
    bus.int_ack = 1'b0;
`ifdef INT_CTRL_EDGE_DETECT_EN
    bus.irq = 8'h00;
    step();
    bus.irq = 8'h10;
    step();
    bus.irq = 8'h00;
`else
    step();
    step();
`endif
    chk("t5_svc", 32'(bus.in_service), 1);
    chk("t5_pend", 32'(bus.pending), 32'h10);
    chk("t5_svc_hw", 32'(bus.hwint), 0);
    bus.int_eoi = 1'b1;
    step();
    bus.int_eoi = 1'b0;
    chk("t5_nonest", 32'(bus.hwint), 0);
    step();
    chk("t5_re_hw", 32'(bus.hwint), 1);
    chk("t5_re_vec", 32'(bus.int_vec), 4);
    bus.int_ack = 1'b1;
    step();
    bus.int_ack = 1'b0;
    chk("t5_svc2", 32'(bus.in_service), 1);
    rst = 1'b1;
    bus.irq = 8'h00;
    bus.int_eoi = 1'b0;
    step();
    rst = 1'b0;
    chk("t5_rst_hw", 32'(bus.hwint), 0);
    chk("t5_rst_vec", 32'(bus.int_vec), 0);
    chk("t5_rst_svc", 32'(bus.in_service), 0);
    chk("t5_rst_pend", 32'(bus.pending), 0);

    // mask cleared by reset; stray ack in IDLE ignored
    bus.irq = 8'h01;
    step();
    bus.irq = 8'h00;
    step();
    chk("t6_mask0_hw", 32'(bus.hwint), 0);
    bus.int_ack = 1'b1;
    step();
    bus.int_ack = 1'b0;
    chk("t6_ack_idle", 32'(bus.in_service), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
